// File: rtl/satatx_scrambler_mw.sv
// SATA link-layer TX scrambler: XORs up to NWORDS 32-bit words per beat with the
// SATA LFSR sequence, one clock of latency, optional skid buffer on the input side.
module satatx_scrambler_mw #(
   parameter logic [15:0] POLYNOMIAL     = 16'ha011,
   parameter logic [15:0] INITIAL        = 16'hffff,
   parameter int          NWORDS         = 1,
   parameter bit          OPT_LOWPOWER   = 1'b1,
   parameter bit          OPT_SKIDBUFFER = 1'b0
) (
   input  logic                   S_AXI_ACLK,
   input  logic                   S_AXI_ARESET,
   input  logic                   i_abort,
   input  logic                   i_enable,
   input  logic                   S_AXIS_TVALID,
   output logic                   S_AXIS_TREADY,
   input  logic [32*NWORDS-1:0]   S_AXIS_TDATA,
   input  logic [NWORDS-1:0]      S_AXIS_TKEEP,
   input  logic                   S_AXIS_TLAST,
   input  logic                   S_AXIS_TUSER,
   output logic                   M_AXIS_TVALID,
   input  logic                   M_AXIS_TREADY,
   output logic [32*NWORDS-1:0]   M_AXIS_TDATA,
   output logic [NWORDS-1:0]      M_AXIS_TKEEP,
   output logic                   M_AXIS_TLAST,
   output logic                   M_AXIS_TUSER
);
   localparam int DW = 32 * NWORDS;
   localparam int CW = $clog2(NWORDS + 1);

   // Returns {fill after 32 shifts, 32 PRN bits LSB-first}.
   function automatic logic [47:0] lfsr_step32(input logic [15:0] fill_in);
      logic [15:0] f;
      logic [31:0] prn;
      f   = fill_in;
      prn = 32'h0000_0000;
      for (int k = 0; k < 32; k++) begin
         prn[k] = f[15];
         f      = {f[14:0], 1'b0} ^ (f[15] ? POLYNOMIAL : 16'h0000);
      end
      return {f, prn};
   endfunction

   logic [15:0]     fill_r;
   logic [15:0]     walk_s;
   logic [15:0]     fills_s [0:NWORDS];
   logic [31:0]     prn_s   [0:NWORDS-1];
   logic [CW-1:0]   keep_cnt_s;
   logic [15:0]     next_fill_s;
   logic            pass_s;
   logic [DW-1:0]   beat_data_s;

   logic            out_free_s;
   logic            s_ready_s;
   logic            accept_s;
   logic            in_to_out_s;
   logic            load_skid_s;
   logic            skid_to_out_s;

   logic            skid_valid_r;
   logic [DW-1:0]   skid_data_r;
   logic [NWORDS-1:0] skid_keep_r;
   logic            skid_last_r;
   logic            skid_user_r;

   logic            m_valid_r;
   logic [DW-1:0]   m_data_r;
   logic [NWORDS-1:0] m_keep_r;
   logic            m_last_r;
   logic            m_user_r;

   // Fill after 0..NWORDS kept words, plus the PRN block each word would use
   always_comb begin
      walk_s     = fill_r;
      fills_s[0] = fill_r;
      for (int i = 0; i < NWORDS; i++) begin
         {walk_s, prn_s[i]} = lfsr_step32(walk_s);
         fills_s[i + 1]     = walk_s;
      end
   end

   // Word count, selected next fill and the scrambled beat
   always_comb begin
      keep_cnt_s = {CW{1'b0}};
      for (int i = 0; i < NWORDS; i++) begin
         keep_cnt_s = keep_cnt_s + CW'(S_AXIS_TKEEP[i]);
      end
      next_fill_s = fills_s[keep_cnt_s];
      pass_s      = S_AXIS_TUSER || !i_enable;
      beat_data_s = {DW{1'b0}};
      for (int i = 0; i < NWORDS; i++) begin
         if (!S_AXIS_TKEEP[i] && OPT_LOWPOWER) begin
            beat_data_s[32*i +: 32] = 32'h0000_0000;
         end else if (pass_s) begin
            beat_data_s[32*i +: 32] = S_AXIS_TDATA[32*i +: 32];
         end else begin
            beat_data_s[32*i +: 32] = S_AXIS_TDATA[32*i +: 32] ^ prn_s[i];
         end
      end
   end

   // Handshake decode; the skid path only exists when OPT_SKIDBUFFER is set
   always_comb begin
      out_free_s = !m_valid_r || M_AXIS_TREADY;
      if (OPT_SKIDBUFFER) begin
         s_ready_s = !skid_valid_r && !i_abort;
      end else begin
         s_ready_s = !i_abort && out_free_s;
      end
      accept_s      = S_AXIS_TVALID && s_ready_s;
      in_to_out_s   = accept_s && out_free_s;
      load_skid_s   = OPT_SKIDBUFFER && accept_s && !out_free_s;
      skid_to_out_s = OPT_SKIDBUFFER && skid_valid_r && out_free_s;
   end

   // LFSR fill: reseed on reset, abort or an accepted TLAST beat
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         fill_r <= INITIAL;
      end else if (i_abort) begin
         fill_r <= INITIAL;
      end else if (accept_s && S_AXIS_TLAST) begin
         fill_r <= INITIAL;
      end else if (accept_s && !pass_s) begin
         fill_r <= next_fill_s;
      end else begin
         fill_r <= fill_r;
      end
   end

   // Skid entry holds an already-scrambled beat so the fill advances in acceptance order
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         skid_valid_r <= 1'b0;
         skid_data_r  <= {DW{1'b0}};
         skid_keep_r  <= {NWORDS{1'b0}};
         skid_last_r  <= 1'b0;
         skid_user_r  <= 1'b0;
      end else if (i_abort) begin
         skid_valid_r <= 1'b0;
      end else if (load_skid_s) begin
         skid_valid_r <= 1'b1;
         skid_data_r  <= beat_data_s;
         skid_keep_r  <= S_AXIS_TKEEP;
         skid_last_r  <= S_AXIS_TLAST;
         skid_user_r  <= S_AXIS_TUSER;
      end else if (skid_to_out_s) begin
         skid_valid_r <= 1'b0;
      end else begin
         skid_valid_r <= skid_valid_r;
      end
   end

   // Output register; payload only changes when the downstream can take it
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         m_valid_r <= 1'b0;
         m_data_r  <= {DW{1'b0}};
         m_keep_r  <= {NWORDS{1'b0}};
         m_last_r  <= 1'b0;
         m_user_r  <= 1'b0;
      end else if (i_abort || (!skid_to_out_s && !in_to_out_s && M_AXIS_TREADY)) begin
         m_valid_r <= 1'b0;
         if (OPT_LOWPOWER) begin
            m_data_r <= {DW{1'b0}};
            m_keep_r <= {NWORDS{1'b0}};
            m_last_r <= 1'b0;
            m_user_r <= 1'b0;
         end
      end else if (skid_to_out_s) begin
         m_valid_r <= 1'b1;
         m_data_r  <= skid_data_r;
         m_keep_r  <= skid_keep_r;
         m_last_r  <= skid_last_r;
         m_user_r  <= skid_user_r;
      end else if (in_to_out_s) begin
         m_valid_r <= 1'b1;
         m_data_r  <= beat_data_s;
         m_keep_r  <= S_AXIS_TKEEP;
         m_last_r  <= S_AXIS_TLAST;
         m_user_r  <= S_AXIS_TUSER;
      end else begin
         m_valid_r <= m_valid_r;
      end
   end

   assign S_AXIS_TREADY = s_ready_s;
   assign M_AXIS_TVALID = m_valid_r;
   assign M_AXIS_TDATA  = m_data_r;
   assign M_AXIS_TKEEP  = m_keep_r;
   assign M_AXIS_TLAST  = m_last_r;
   assign M_AXIS_TUSER  = m_user_r;

endmodule
